// File: rtl/multicycle_main_control_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_main_control_pkg
// Shared constants for the multi-cycle main control FSM:
//   - opcode / funct constants decoded from the instruction register
//   - ALUOp codes handed to the ALU control decoder
//   - ALUSrcB and PCSource mux encodings
//   - 4-bit FSM state encodings
//   - ctrl_t: the bundle of datapath controls driven each cycle
// -----------------------------------------------------------------------------
package multicycle_main_control_pkg;

  // Opcodes (IR[31:26]) and the jump-register funct (IR[5:0])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // ALUOp codes consumed by the ALU control decoder
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_ADDI  = 3'b010;
  localparam logic [2:0] ALUOP_SUBI  = 3'b011;
  localparam logic [2:0] ALUOP_RTYPE = 3'b100;

  // ALU operand B select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  // FSM state encodings
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_RT_EXEC   = 4'd6;
  localparam logic [3:0] S_RT_WB     = 4'd7;
  localparam logic [3:0] S_IMM_EXEC  = 4'd8;
  localparam logic [3:0] S_IMM_WB    = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_JUMP      = 4'd11;
  localparam logic [3:0] S_JR        = 4'd12;

  // Datapath control bundle; all-zero is the idle / reset value
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/main_ctrl_decode.sv
// -----------------------------------------------------------------------------
// main_ctrl_decode
// Combinational opcode/funct decode used in the DECODE state: selects the
// state that follows DECODE and flags opcodes the machine does not implement.
//   i_opcode     [5:0]  IR[31:26]
//   i_funct      [5:0]  IR[5:0]
//   o_next_state [3:0]  state to enter after DECODE
//   o_illegal           opcode not recognised (next state is FETCH)
// -----------------------------------------------------------------------------
module main_ctrl_decode
  import multicycle_main_control_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [3:0] o_next_state,
  output logic       o_illegal
);

  always_comb begin
    o_next_state = S_FETCH;
    o_illegal    = 1'b0;
    case (i_opcode)
      OP_RTYPE: o_next_state = (i_funct == FUNCT_JR) ? S_JR : S_RT_EXEC;
      OP_LW,
      OP_SW:    o_next_state = S_MEM_ADDR;
      OP_BEQ:   o_next_state = S_BRANCH;
      OP_ADDI,
      OP_SUBI:  o_next_state = S_IMM_EXEC;
      OP_J:     o_next_state = S_JUMP;
      default: begin
        o_next_state = S_FETCH;
        o_illegal    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// -----------------------------------------------------------------------------
// multicycle_main_control
// Moore main-control FSM for the multi-cycle datapath. Sequences
// fetch / decode / execute / memory / writeback and stalls on mem_ready in
// the memory-access states.
//   clk, rst          clock, asynchronous active-high reset
//   opcode, funct     instruction fields, sampled in DECODE
//   mem_ready         current memory access complete (FETCH, MEM_READ, MEM_WRITE)
//   PCWrite .. ALUOp  datapath enables and mux selects
//   illegal_op        registered one-cycle pulse after an unknown opcode
//   state             current FSM state (debug)
// -----------------------------------------------------------------------------
module multicycle_main_control
  import multicycle_main_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       illegal_op,
  output logic [3:0] state
);

  logic [3:0] r_state;
  logic       r_is_subi;   // IMM_EXEC op chosen at DECODE, immune to later IR changes
  logic       r_is_store;  // MEM_ADDR successor chosen at DECODE
  logic       r_illegal;

  logic [3:0] w_decode_next;
  logic       w_decode_illegal;
  logic [3:0] w_next_state;
  ctrl_t      w_ctrl;
  ctrl_t      w_ctrl_out;

  main_ctrl_decode u_decode (
    .i_opcode     (opcode),
    .i_funct      (funct),
    .o_next_state (w_decode_next),
    .o_illegal    (w_decode_illegal)
  );

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:     w_next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    w_next_state = w_decode_next;
      S_MEM_ADDR:  w_next_state = r_is_store ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  w_next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: w_next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_RT_EXEC:   w_next_state = S_RT_WB;
      S_IMM_EXEC:  w_next_state = S_IMM_WB;
      default:     w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_is_subi  <= 1'b0;
      r_is_store <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_illegal <= (r_state == S_DECODE) && w_decode_illegal;
      if (r_state == S_DECODE) begin
        r_is_subi  <= (opcode == OP_SUBI);
        r_is_store <= (opcode == OP_SW);
      end
    end
  end

  // Moore outputs; FETCH additionally qualifies IRWrite/PCWrite with
  // mem_ready so the IR and PC only load when the fetch data is valid.
  always_comb begin
    w_ctrl = CTRL_IDLE;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.pc_source = PCSRC_ALU;
        w_ctrl.ir_write  = mem_ready;
        w_ctrl.pc_write  = mem_ready;
      end
      S_DECODE:    w_ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.iord      = 1'b1;
      end
      S_RT_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_B;
        w_ctrl.alu_op    = ALUOP_RTYPE;
      end
      S_RT_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
      end
      S_IMM_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = r_is_subi ? ALUOP_SUBI : ALUOP_ADDI;
      end
      S_IMM_WB:    w_ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRCB_B;
        w_ctrl.alu_op        = ALUOP_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_JUMP;
      end
      S_JR: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_REG;
      end
      default:     w_ctrl = CTRL_IDLE;
    endcase
  end

  // The reset state is FETCH, whose controls are not idle; force everything
  // idle while rst is held so nothing strobes during reset.
  assign w_ctrl_out = rst ? CTRL_IDLE : w_ctrl;

  assign PCWrite     = w_ctrl_out.pc_write;
  assign PCWriteCond = w_ctrl_out.pc_write_cond;
  assign IorD        = w_ctrl_out.iord;
  assign MemRead     = w_ctrl_out.mem_read;
  assign MemWrite    = w_ctrl_out.mem_write;
  assign IRWrite     = w_ctrl_out.ir_write;
  assign MemtoReg    = w_ctrl_out.mem_to_reg;
  assign RegDst      = w_ctrl_out.reg_dst;
  assign RegWrite    = w_ctrl_out.reg_write;
  assign ALUSrcA     = w_ctrl_out.alu_src_a;
  assign ALUSrcB     = w_ctrl_out.alu_src_b;
  assign PCSource    = w_ctrl_out.pc_source;
  assign ALUOp       = w_ctrl_out.alu_op;
  assign illegal_op  = r_illegal;
  assign state       = r_state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_main_control
// Directed cycle-by-cycle checks of state, the full control word and
// illegal_op against hand-written expectations.
// -----------------------------------------------------------------------------
module tb_multicycle_main_control;
  import multicycle_main_control_pkg::*;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic       illegal_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  // Control word bit masks:
  // [16]PCWrite [15]PCWriteCond [14]IorD [13]MemRead [12]MemWrite [11]IRWrite
  // [10]MemtoReg [9]RegDst [8]RegWrite [7]ALUSrcA [6:5]ALUSrcB [4:3]PCSource [2:0]ALUOp
  localparam logic [16:0] PCW    = 17'h10000;
  localparam logic [16:0] PCWC   = 17'h08000;
  localparam logic [16:0] IORD   = 17'h04000;
  localparam logic [16:0] MRD    = 17'h02000;
  localparam logic [16:0] MWR    = 17'h01000;
  localparam logic [16:0] IRW    = 17'h00800;
  localparam logic [16:0] M2R    = 17'h00400;
  localparam logic [16:0] RDST   = 17'h00200;
  localparam logic [16:0] RWR    = 17'h00100;
  localparam logic [16:0] SRCA   = 17'h00080;
  localparam logic [16:0] SB_4   = 17'h00020;
  localparam logic [16:0] SB_IMM = 17'h00040;
  localparam logic [16:0] SB_SH2 = 17'h00060;
  localparam logic [16:0] PS_OUT = 17'h00008;
  localparam logic [16:0] PS_J   = 17'h00010;
  localparam logic [16:0] PS_A   = 17'h00018;
  localparam logic [16:0] AO_SUB = 17'h00001;
  localparam logic [16:0] AO_ADI = 17'h00002;
  localparam logic [16:0] AO_SBI = 17'h00003;
  localparam logic [16:0] AO_RT  = 17'h00004;

  localparam logic [16:0] FETCH_WAIT = MRD | SB_4;
  localparam logic [16:0] FETCH_GO   = MRD | SB_4 | IRW | PCW;

  logic [16:0] obs_ctl;
  assign obs_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp};

  multicycle_main_control dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .funct       (funct),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .illegal_op  (illegal_op),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One cycle: drive mem_ready, check outputs mid-cycle, advance to next negedge.
  task automatic step(input string tag, input logic mr, input logic [3:0] exp_state,
                      input logic [16:0] exp_ctl, input logic exp_ill);
    mem_ready = mr;
    #1;
    chk({tag, ".state"}, {28'd0, state}, {28'd0, exp_state});
    chk({tag, ".ctl"}, {15'd0, obs_ctl}, {15'd0, exp_ctl});
    chk({tag, ".ill"}, {31'd0, illegal_op}, {31'd0, exp_ill});
    $display("step %-14s state=%0d ctl=%05h ill=%0b", tag, state, obs_ctl, illegal_op);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; opcode = 6'd0; funct = 6'd0; mem_ready = 1'b0;
    @(negedge clk);
    step("reset", 1'b1, S_FETCH, 17'd0, 1'b0);
    rst = 1'b0;

    // R-type add, mem_ready ignored (low) outside FETCH
    opcode = 6'b000000; funct = 6'b100000;
    step("rt.fetch",  1'b1, S_FETCH,   FETCH_GO, 1'b0);
    step("rt.decode", 1'b0, S_DECODE,  SB_SH2, 1'b0);
    step("rt.exec",   1'b0, S_RT_EXEC, SRCA | AO_RT, 1'b0);
    step("rt.wb",     1'b0, S_RT_WB,   RWR | RDST, 1'b0);

    // LW with two FETCH stalls and one MEM_READ stall: 8 cycles
    opcode = 6'b100011;
    step("lw.fetch0", 1'b0, S_FETCH,    FETCH_WAIT, 1'b0);
    step("lw.fetch1", 1'b0, S_FETCH,    FETCH_WAIT, 1'b0);
    step("lw.fetch2", 1'b1, S_FETCH,    FETCH_GO, 1'b0);
    step("lw.decode", 1'b1, S_DECODE,   SB_SH2, 1'b0);
    step("lw.addr",   1'b1, S_MEM_ADDR, SRCA | SB_IMM, 1'b0);
    step("lw.rd0",    1'b0, S_MEM_READ, MRD | IORD, 1'b0);
    step("lw.rd1",    1'b1, S_MEM_READ, MRD | IORD, 1'b0);
    step("lw.wb",     1'b1, S_MEM_WB,   RWR | M2R, 1'b0);

    // SUBI then ADDI; opcode changes to ADDI during SUBI's IMM_EXEC
    opcode = 6'b001001;
    step("subi.fetch",  1'b1, S_FETCH,    FETCH_GO, 1'b0);
    step("subi.decode", 1'b1, S_DECODE,   SB_SH2, 1'b0);
    opcode = 6'b001000;
    step("subi.exec",   1'b1, S_IMM_EXEC, SRCA | SB_IMM | AO_SBI, 1'b0);
    step("subi.wb",     1'b1, S_IMM_WB,   RWR, 1'b0);
    step("addi.fetch",  1'b1, S_FETCH,    FETCH_GO, 1'b0);
    step("addi.decode", 1'b1, S_DECODE,   SB_SH2, 1'b0);
    step("addi.exec",   1'b1, S_IMM_EXEC, SRCA | SB_IMM | AO_ADI, 1'b0);
    step("addi.wb",     1'b1, S_IMM_WB,   RWR, 1'b0);

    // SW with one MEM_WRITE stall
    opcode = 6'b101011;
    step("sw.fetch",  1'b1, S_FETCH,     FETCH_GO, 1'b0);
    step("sw.decode", 1'b1, S_DECODE,    SB_SH2, 1'b0);
    step("sw.addr",   1'b1, S_MEM_ADDR,  SRCA | SB_IMM, 1'b0);
    step("sw.wr0",    1'b0, S_MEM_WRITE, MWR | IORD, 1'b0);
    step("sw.wr1",    1'b1, S_MEM_WRITE, MWR | IORD, 1'b0);

    // BEQ, J, JR: 3 cycles each
    opcode = 6'b000100;
    step("beq.fetch",  1'b1, S_FETCH,  FETCH_GO, 1'b0);
    step("beq.decode", 1'b1, S_DECODE, SB_SH2, 1'b0);
    step("beq.branch", 1'b1, S_BRANCH, SRCA | AO_SUB | PCWC | PS_OUT, 1'b0);
    opcode = 6'b000010;
    step("j.fetch",    1'b1, S_FETCH,  FETCH_GO, 1'b0);
    step("j.decode",   1'b1, S_DECODE, SB_SH2, 1'b0);
    step("j.jump",     1'b1, S_JUMP,   PCW | PS_J, 1'b0);
    opcode = 6'b000000; funct = 6'b001000;
    step("jr.fetch",   1'b1, S_FETCH,  FETCH_GO, 1'b0);
    step("jr.decode",  1'b1, S_DECODE, SB_SH2, 1'b0);
    step("jr.jr",      1'b1, S_JR,     PCW | PS_A, 1'b0);

    // Illegal opcode: one-cycle illegal_op pulse back in FETCH
    opcode = 6'b111111;
    step("ill.fetch",  1'b1, S_FETCH,  FETCH_GO, 1'b0);
    step("ill.decode", 1'b1, S_DECODE, SB_SH2, 1'b0);
    step("ill.pulse",  1'b0, S_FETCH,  FETCH_WAIT, 1'b1);
    step("ill.after",  1'b0, S_FETCH,  FETCH_WAIT, 1'b0);

    // Reset in the middle of an LW MEM_READ stall
    opcode = 6'b100011;
    step("lwr.fetch",  1'b1, S_FETCH,    FETCH_GO, 1'b0);
    step("lwr.decode", 1'b1, S_DECODE,   SB_SH2, 1'b0);
    step("lwr.addr",   1'b1, S_MEM_ADDR, SRCA | SB_IMM, 1'b0);
    mem_ready = 1'b0;
    #1;
    chk("lwr.rd.state", {28'd0, state}, {28'd0, S_MEM_READ});
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.state", {28'd0, state}, {28'd0, S_FETCH});
    chk("midrst.ctl", {15'd0, obs_ctl}, 32'd0);
    $display("step %-14s state=%0d ctl=%05h", "midrst", state, obs_ctl);
    @(negedge clk);
    step("midrst.hold", 1'b1, S_FETCH, 17'd0, 1'b0);
    rst = 1'b0;
    step("postrst", 1'b0, S_FETCH, FETCH_WAIT, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multi-cycle main control FSM.
- Decodes the 6-bit opcode and the R-type funct field, then sequences the datapath through fetch, decode, execute, memory and writeback.
- It is the producer of the 3-bit ALUOp code that the ALU control decoder consumes, and of every datapath enable.
- Sits between the instruction register and the datapath muxes/enables.
- Also owns instruction-memory wait handling through a ready handshake.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode.
- OP_LW, 6'b100011, load word.
- OP_SW, 6'b101011, store word.
- OP_BEQ, 6'b000100, branch if equal.
- OP_ADDI, 6'b001000, add immediate.
- OP_SUBI, 6'b001001, subtract immediate.
- OP_J, 6'b000010, jump.
- FUNCT_JR, 6'b001000, jump-register funct.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- opcode  input  6  IR[31:26]; sampled in DECODE
- funct  input  6  IR[5:0]; sampled in DECODE
- mem_ready  input  1  memory has completed the current access
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU zero
- IorD  output  1  0 = PC address, 1 = ALUOut address
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  writeback source: 1 = MDR
- RegDst  output  1  destination register: 1 = rd
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0 = PC, 1 = A
- ALUSrcB  output  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm << 2
- PCSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = A (jr)
- ALUOp  output  3  000 add, 001 sub, 010 addi, 011 subi, 100 R-type (funct decode)
- illegal_op  output  1  one-cycle pulse on unknown opcode
- state  output  4  current state, for debug

Behaviour:
- Moore FSM. All outputs are a function of the registered state only, except illegal_op, which is registered.
- Reset: state = FETCH. Every strobe output is 0; ALUOp = 000; muxes select 0.
  - While rst is high, no strobe is asserted.
  - Reset mid-instruction abandons the instruction immediately; there is no partial writeback.
- Outputs by state (signals not listed are 0; ALUOp = 000 unless stated):
  - FETCH: MemRead = 1, ALUSrcB = 01. IRWrite and PCWrite are asserted only in the cycle where mem_ready = 1.
    - mem_ready = 1 → DECODE. Otherwise remain in FETCH, holding MemRead.
  - DECODE: ALUSrcB = 11 (precomputes the branch target). Next state by opcode:
    - RTYPE with funct == FUNCT_JR → JR.
    - RTYPE otherwise → RT_EXEC.
    - LW or SW → MEM_ADDR.
    - BEQ → BRANCH.
    - ADDI or SUBI → IMM_EXEC.
    - J → JUMP.
    - Anything else → FETCH, with illegal_op = 1 for exactly one cycle.
  - MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10. LW → MEM_READ; SW → MEM_WRITE.
  - MEM_READ: MemRead = 1, IorD = 1. Waits for mem_ready, then → MEM_WB.
  - MEM_WB: RegWrite = 1, MemtoReg = 1, RegDst = 0. → FETCH.
  - MEM_WRITE: MemWrite = 1, IorD = 1. Waits for mem_ready, then → FETCH.
  - RT_EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 100. → RT_WB.
  - RT_WB: RegWrite = 1, RegDst = 1. → FETCH.
  - IMM_EXEC: ALUSrcA = 1, ALUSrcB = 10. ALUOp = 010 for ADDI, 011 for SUBI. → IMM_WB.
  - IMM_WB: RegWrite = 1, RegDst = 0. → FETCH.
  - BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 001, PCWriteCond = 1, PCSource = 01. → FETCH.
  - JUMP: PCWrite = 1, PCSource = 10. → FETCH.
  - JR: PCWrite = 1, PCSource = 11. → FETCH.
- The ADDI/SUBI distinction is latched in a 1-bit register at DECODE, so a change on opcode after IR update cannot alter ALUOp in IMM_EXEC.
- Instruction latencies, counted from FETCH entry with mem_ready = 1 on every access:
  - J, JR, BEQ: 3 cycles.
  - R-type, ADDI, SUBI, SW: 4 cycles.
  - LW: 5 cycles.
- Each cycle with mem_ready = 0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- mem_ready is ignored in every other state.
- The state encoding for undefined values is unreachable; default → FETCH with all outputs 0.

Decomposition:
- Shared package/header holds:
  - opcode and funct constants;
  - ALUOp code constants (000–100);
  - ALUSrcB and PCSource encodings;
  - the 4-bit state encodings.
- ALU control decoding and JR datapath selection remain in their existing modules; this block only produces ALUOp/PCSource.
- One sub-module is natural: main_ctrl_decode, the combinational mapping of opcode/funct to next-state from DECODE, plus illegal detection.

Test Plan:
- Reset asserted mid-MEM_READ of LW (mem_ready = 0) → within the same cycle, state = FETCH and all strobes = 0; after release, MemRead = 1 with IorD = 0.
- R-type add (opcode 000000, funct 100000), mem_ready tied 1 → state sequence FETCH, DECODE, RT_EXEC, RT_WB; ALUOp = 100 in RT_EXEC; RegWrite = 1 and RegDst = 1 only in RT_WB; 4 cycles total.
- LW with mem_ready low for 2 cycles in FETCH and 1 cycle in MEM_READ → 8 cycles total; IRWrite pulses once; RegWrite with MemtoReg = 1 only in MEM_WB.
- SUBI (001001), then ADDI (001000) back-to-back → ALUOp = 011 then 010 in the respective IMM_EXEC cycles; ALUSrcB = 10 in both.
- BEQ (000100) → BRANCH with ALUOp = 001, PCWriteCond = 1, PCSource = 01; 3 cycles. JR (000000/001000) → PCWrite = 1, PCSource = 11; 3 cycles.
- Illegal opcode 111111 → illegal_op high for exactly one cycle, return to FETCH, no RegWrite, MemWrite or PCWrite outside FETCH.
